// File: rtl/clk_rst_seq_if.sv
// Signal bundle between the clock/reset sequencer and its surroundings.
// The master drives lock, realignment and clear; the slave is the sequencer itself.
interface clk_rst_seq_if #(
  parameter int NCH    = 3,
  parameter int LOSS_W = 8
);
  logic              pll_lock;
  logic              resync;
  logic              lost_clr;
  logic              sys_rst_n;
  logic              running;
  logic [NCH-1:0]    ce;
  logic              lock_lost;
  logic [LOSS_W-1:0] loss_cnt;

  modport master (
    output pll_lock, resync, lost_clr,
    input  sys_rst_n, running, ce, lock_lost, loss_cnt
  );

  modport slave (
    input  pll_lock, resync, lost_clr,
    output sys_rst_n, running, ce, lock_lost, loss_cnt
  );
endinterface

// File: rtl/clk_rst_seq.sv
// PLL lock qualifier and reset sequencer with per-channel divided clock-enable strobes
// and sticky lock-loss bookkeeping, all on the single PLL output clock.
module clk_rst_seq #(
  parameter int                   NCH       = 3,
  parameter int                   DIV_W     = 17,
  parameter logic [NCH*DIV_W-1:0] DIV_LIST  = {17'd64800, 17'd2, 17'd1},
  parameter int                   LOCK_SYNC = 2,
  parameter int                   RST_HOLD  = 16,
  parameter int                   LOSS_W    = 8
) (
  input logic          clk,
  input logic          rst_n,
  clk_rst_seq_if.slave bus
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LOCK_SYNC-1:0] sync_chain;
  logic                 lock_s;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [HOLD_W-1:0]    hold_nxt;
  logic                 loss_evt;
  logic                 running;
  logic                 sys_rst_n;
  logic                 lock_lost;
  logic [LOSS_W-1:0]    loss_cnt;
  logic [NCH-1:0]       ce_vec;

  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // pll_lock is asynchronous to clk; only the last stage is used by the FSM
  always_ff @(posedge clk) begin
    if (!rst_n) sync_chain <= '0;
    else        sync_chain <= {sync_chain[LOCK_SYNC-2:0], bus.pll_lock};
  end

  assign lock_s = sync_chain[LOCK_SYNC-1];

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    loss_evt  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end
      end
      HOLD: begin
        if (!lock_s)                    state_nxt = WAIT_LOCK;
        else if (hold_cnt == HOLD_LAST) state_nxt = RUN;
        else                            hold_nxt  = hold_cnt + 1'b1;
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          loss_evt  = 1'b1;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // sys_rst_n and running follow the next state so they change on the state edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      hold_cnt  <= '0;
      running   <= 1'b0;
      sys_rst_n <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      running   <= (state_nxt == RUN);
      sys_rst_n <= (state_nxt == RUN);
    end
  end

  // A loss coinciding with a clear leaves exactly that one event recorded
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_lost <= 1'b0;
      loss_cnt  <= '0;
    end else if (bus.lost_clr) begin
      lock_lost <= loss_evt;
      loss_cnt  <= loss_evt ? LOSS_W'(1) : '0;
    end else if (loss_evt) begin
      lock_lost <= 1'b1;
      loss_cnt  <= sat_inc(loss_cnt);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [DIV_W-1:0] RAW  = DIV_LIST[i*DIV_W +: DIV_W];
    localparam logic [DIV_W-1:0] LAST = (RAW == '0) ? '0 : RAW - 1'b1;

    logic [DIV_W-1:0] cnt;

    // Counters idle at zero outside RUN, which also aligns them on RUN entry
    always_ff @(posedge clk) begin
      if (!rst_n)
        cnt <= '0;
      else if (state != RUN || state_nxt != RUN || bus.resync || cnt == LAST)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end

    assign ce_vec[i] = running & (cnt == LAST);
  end

  assign bus.sys_rst_n = sys_rst_n;
  assign bus.running   = running;
  assign bus.ce        = ce_vec;
  assign bus.lock_lost = lock_lost;
  assign bus.loss_cnt  = loss_cnt;

endmodule
